// File: rtl/blockmem_responder_pkg.sv
// Shared sizing constants and types for the block memory responder.
package blockmem_responder_pkg;

    localparam int unsigned MEM_WORD_SIZE        = 32;
    localparam int unsigned MEM_BLOCK_SIZE       = 256;
    localparam int unsigned MEM_BYTE_SIZE        = 8;
    localparam int unsigned MEM_CACHE_OFFSET_LEN = 5;
    localparam int unsigned MEM_DEPTH_LOG2       = 6;
    localparam int unsigned MEM_LATENCY          = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } bm_state_e;

    // Width of a down-counter that must hold LATENCY-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

endpackage

// File: rtl/blockmem_array.sv
// Block-organised backing store: synchronous write, registered synchronous read.
module blockmem_array
    import blockmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = MEM_DEPTH_LOG2,
    parameter int unsigned BLOCK_SIZE = MEM_BLOCK_SIZE
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [BLOCK_SIZE-1:0] wdata_i,
    output logic [BLOCK_SIZE-1:0] rdata_o
);

    logic [BLOCK_SIZE-1:0] mem_q [2**DEPTH_LOG2];
    logic [BLOCK_SIZE-1:0] rdata_q;

    // Store on write enable; capture the addressed block on read enable.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/blockmem_responder.sv
// Memory-side responder for cache block refill and write-back traffic.
// One request in flight; fixed latency; valid/ready on both channels.
module blockmem_responder
    import blockmem_responder_pkg::*;
#(
    parameter int unsigned WORD_SIZE  = MEM_WORD_SIZE,
    parameter int unsigned BLOCK_SIZE = MEM_BLOCK_SIZE,
    parameter int unsigned DEPTH_LOG2 = MEM_DEPTH_LOG2,
    parameter int unsigned LATENCY    = MEM_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [WORD_SIZE-1:0]  req_addr,
    input  logic [BLOCK_SIZE-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [BLOCK_SIZE-1:0] resp_rdata,
    output logic                  resp_err
);

    localparam int unsigned OFF_W = $clog2(BLOCK_SIZE / MEM_BYTE_SIZE);
    localparam int unsigned CNT_W = cnt_width(LATENCY);
    localparam logic [WORD_SIZE-1:0] HI_MASK = {WORD_SIZE{1'b1}} << (OFF_W + DEPTH_LOG2);

    bm_state_e             state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  req_ready_q;
    logic                  resp_valid_q;
    logic                  resp_err_q;
    logic                  write_q;
    logic                  err_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [BLOCK_SIZE-1:0] wdata_q;

    logic                  addr_err;
    logic [DEPTH_LOG2-1:0] addr_idx;
    logic                  access;
    logic                  arr_we;
    logic                  arr_re;
    logic [BLOCK_SIZE-1:0] arr_rdata;
    logic                  unused_addr;

    assign addr_err    = |(req_addr & HI_MASK);
    assign addr_idx    = req_addr[OFF_W +: DEPTH_LOG2];
    assign unused_addr = ^req_addr[OFF_W-1:0];

    // The array is touched only on the final WAIT edge, so a reset during WAIT
    // leaves it unchanged. Out-of-range requests never reach it.
    assign access = (state_q == ST_WAIT) && (cnt_q == '0);
    assign arr_we = access && write_q && !err_q;
    assign arr_re = access && !write_q && !err_q;

    // Request/response sequencing: IDLE -> WAIT (latency count) -> RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            write_q      <= 1'b0;
            err_q        <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_q     <= req_write;
                        err_q       <= addr_err;
                        idx_q       <= addr_idx;
                        wdata_q     <= req_wdata;
                        cnt_q       <= CNT_W'(LATENCY - 1);
                        req_ready_q <= 1'b0;
                        state_q     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= err_q;
                        state_q      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    blockmem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .BLOCK_SIZE (BLOCK_SIZE)
    ) u_array (
        .clk_i   (clk),
        .we_i    (arr_we),
        .re_i    (arr_re),
        .addr_i  (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (arr_rdata)
    );

    // Read data lives in the array's output register; it is exposed only while
    // a successful read response is pending, which gives zero for writes,
    // errors, idle and reset without a second 256-bit register.
    assign resp_rdata = (resp_valid_q && !resp_err_q && !write_q) ? arr_rdata : '0;
    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_blockmem_responder.sv
// Directed self-checking bench for blockmem_responder (LATENCY=4 and LATENCY=1 builds).
module tb_blockmem_responder;

    logic         clk;
    logic         rst;

    logic         req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err;
    logic [31:0]  req_addr;
    logic [255:0] req_wdata, resp_rdata;

    logic         r1_req_valid, r1_req_ready, r1_req_write, r1_resp_valid, r1_resp_ready, r1_resp_err;
    logic [31:0]  r1_req_addr;
    logic [255:0] r1_req_wdata, r1_resp_rdata;

    int checks   = 0;
    int failures = 0;

    localparam logic [255:0] PAT_P = {2{128'h00112233445566778899AABBCCDDEEFF}};
    localparam logic [255:0] PAT_Q = {8{32'hCAFE_0001}};
    localparam logic [255:0] PAT_R = {4{64'h0123_4567_89AB_CDEF}};
    localparam logic [255:0] PAT_S = {16{16'hA55A}};
    localparam logic [255:0] PAT_J = {32{8'h5C}};

    blockmem_responder #(
        .WORD_SIZE  (32),
        .BLOCK_SIZE (256),
        .DEPTH_LOG2 (6),
        .LATENCY    (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    blockmem_responder #(
        .WORD_SIZE  (32),
        .BLOCK_SIZE (256),
        .DEPTH_LOG2 (6),
        .LATENCY    (1)
    ) dut1 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (r1_req_valid),
        .req_ready  (r1_req_ready),
        .req_write  (r1_req_write),
        .req_addr   (r1_req_addr),
        .req_wdata  (r1_req_wdata),
        .resp_valid (r1_resp_valid),
        .resp_ready (r1_resp_ready),
        .resp_rdata (r1_resp_rdata),
        .resp_err   (r1_resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request on the LATENCY=4 instance and return once it was accepted.
    task automatic issue(input logic w, input logic [31:0] a, input logic [255:0] d, input string tag);
        int n;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_accept_timeout"}, 256'(n < 100), 256'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
        // Scramble the bus after acceptance: latched values must be used.
        req_write = ~w;
        req_addr  = 32'hFFFF_FFE0;
        req_wdata = '1;
    endtask

    // Count edges from acceptance until resp_valid is seen.
    task automatic wait_resp(output int lat);
        lat = 0;
        while (!resp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic xact(input logic w, input logic [31:0] a, input logic [255:0] d, input string tag,
                        output logic [255:0] rd, output logic er);
        int lat;
        issue(w, a, d, tag);
        wait_resp(lat);
        chk({tag, "_latency"}, 256'(lat), 256'(4));
        rd = resp_rdata;
        er = resp_err;
        handshake();
    endtask

    initial begin
        logic [255:0] rd;
        logic         er;
        int           lat;

        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        r1_req_valid = 1'b0; r1_req_write = 1'b0; r1_req_addr = '0; r1_req_wdata = '0; r1_resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready",  256'(req_ready),  256'(1));
        chk("rst_resp_valid", 256'(resp_valid), 256'(0));
        chk("rst_resp_rdata", resp_rdata,       '0);
        chk("rst_resp_err",   256'(resp_err),   256'(0));
        rst = 1'b0;

        // Give blocks that are read before being written a known value.
        xact(1'b1, 32'h0000_0040, '0, "clr40", rd, er);

        // Reset while a write to 0x40 is still in WAIT: write must be discarded.
        issue(1'b1, 32'h0000_0040, PAT_J, "rstw");
        @(posedge clk); #1;
        chk("rstw_in_wait_ready", 256'(req_ready), 256'(0));
        rst = 1'b1;
        #2;
        chk("rstw_async_ready", 256'(req_ready), 256'(1));
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rstw_next_ready", 256'(req_ready),  256'(1));
        chk("rstw_next_valid", 256'(resp_valid), 256'(0));
        xact(1'b0, 32'h0000_0040, '0, "rstw_rd", rd, er);
        chk("rstw_rd_data", rd, '0);

        // Write/read round trip with the offset bits ignored on the read.
        xact(1'b1, 32'h0000_0060, PAT_P, "wr60", rd, er);
        chk("wr60_rdata", rd, '0);
        chk("wr60_err",   256'(er), 256'(0));
        xact(1'b0, 32'h0000_007C, '0, "rd7c", rd, er);
        chk("rd7c_rdata", rd, PAT_P);
        chk("rd7c_byte0", 256'(rd[255:248]), 256'(8'h00));
        chk("rd7c_err",   256'(er), 256'(0));

        // Out of range: error, zero data, array untouched.
        xact(1'b1, 32'h0000_0000, PAT_Q, "wr0", rd, er);
        xact(1'b0, 32'h0000_0800, '0, "oor_rd", rd, er);
        chk("oor_rd_err",   256'(er), 256'(1));
        chk("oor_rd_rdata", rd, '0);
        xact(1'b0, 32'h0000_0000, '0, "rd0", rd, er);
        chk("rd0_rdata", rd, PAT_Q);
        xact(1'b1, 32'h0000_0840, PAT_J, "oor_wr", rd, er);
        chk("oor_wr_err", 256'(er), 256'(1));
        xact(1'b0, 32'h0000_0040, '0, "rd40_after_oor", rd, er);
        chk("rd40_after_oor_rdata", rd, '0);
        chk("rd40_after_oor_err",   256'(er), 256'(0));

        // Response backpressure with a competing request held on the bus.
        issue(1'b0, 32'h0000_0060, '0, "bp");
        wait_resp(lat);
        chk("bp_latency", 256'(lat), 256'(4));
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0060; req_wdata = PAT_J;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_valid_%0d", i), 256'(resp_valid), 256'(1));
            chk($sformatf("bp_rdata_%0d", i), resp_rdata,       PAT_P);
            chk($sformatf("bp_ready_%0d", i), 256'(req_ready),  256'(0));
        end
        req_valid = 1'b0;
        handshake();
        chk("bp_done_valid", 256'(resp_valid), 256'(0));
        chk("bp_done_rdata", resp_rdata,       '0);
        xact(1'b0, 32'h0000_0060, '0, "bp_check", rd, er);
        chk("bp_check_rdata", rd, PAT_P);

        // Back-to-back eviction write then refill read of the same block.
        issue(1'b1, 32'h0000_0020, PAT_R, "b2b_wr");
        wait_resp(lat);
        chk("b2b_wr_latency", 256'(lat), 256'(4));
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0020; req_wdata = '0;
        handshake();
        chk("b2b_idle_ready", 256'(req_ready),  256'(1));
        chk("b2b_idle_valid", 256'(resp_valid), 256'(0));
        @(posedge clk); #1;
        chk("b2b_accepted", 256'(req_ready), 256'(0));
        req_valid = 1'b0;
        wait_resp(lat);
        chk("b2b_rd_latency", 256'(lat), 256'(4));
        chk("b2b_rd_rdata", resp_rdata, PAT_R);
        handshake();

        // LATENCY=1 build: response after the edge following acceptance.
        r1_req_valid = 1'b1; r1_req_write = 1'b1; r1_req_addr = 32'h0000_0020; r1_req_wdata = PAT_S;
        chk("l1_ready", 256'(r1_req_ready), 256'(1));
        @(posedge clk); #1;
        r1_req_valid = 1'b0;
        chk("l1_wr_valid_n",  256'(r1_resp_valid), 256'(0));
        @(posedge clk); #1;
        chk("l1_wr_valid_n1", 256'(r1_resp_valid), 256'(1));
        chk("l1_wr_rdata",    r1_resp_rdata, '0);
        r1_resp_ready = 1'b1;
        @(posedge clk); #1;
        r1_resp_ready = 1'b0;
        r1_req_valid = 1'b1; r1_req_write = 1'b0; r1_req_addr = 32'h0000_0020;
        @(posedge clk); #1;
        r1_req_valid = 1'b0;
        chk("l1_rd_valid_n",  256'(r1_resp_valid), 256'(0));
        @(posedge clk); #1;
        chk("l1_rd_valid_n1", 256'(r1_resp_valid), 256'(1));
        chk("l1_rd_rdata",    r1_resp_rdata, PAT_S);
        r1_resp_ready = 1'b1;
        @(posedge clk); #1;
        r1_resp_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
